jk_ff_checker: RTL

//  Downstream self-checking monitor for the JK flip-flop built three ways (SR-, D-, T-based).

---
 rtl/jk_ff_checker.sv | 116 +++++++++++
 1 files changed

// File: rtl/jk_ff_checker.sv
// Self-checking monitor for three JK flip-flop implementations: runs a golden JK
// register alongside the DUTs, flags per-implementation miscompares, keeps saturating counts.
module jk_ff_checker #(
  parameter int CNT_W         = 8,
  parameter int WARMUP_CYCLES = 1,
  parameter bit STOP_ON_ERR   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             J,
  input  logic             K,
  input  logic             Q_sr,
  input  logic             Q_d,
  input  logic             Q_t,
  output logic             golden_q,
  output logic             mismatch,
  output logic [2:0]       mismatch_vec,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] chk_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    CHECK  = 2'd2,
    FAIL   = 2'd3
  } state_t;

  localparam int WW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam logic [WW-1:0]    WARM_LAST = WW'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam state_t           RESTART   = (WARMUP_CYCLES == 0) ? CHECK : WARMUP;

  state_t        state_q;
  logic [WW-1:0] warm_cnt;
  logic [2:0]    cmp_vec;
  logic          q_major;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    case ({j, k})
      2'b00:   return q;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~q;
    endcase
  endfunction

  always_comb begin
    cmp_vec = {Q_t ^ golden_q, Q_d ^ golden_q, Q_sr ^ golden_q};
    q_major = (Q_sr & Q_d) | (Q_sr & Q_t) | (Q_d & Q_t);
  end

  assign state = state_q;

  // NOTE: all state here updates with <= so every term on the right-hand side
  // reads the pre-edge value, which is exactly the compare alignment we need.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      warm_cnt     <= '0;
      golden_q     <= 1'b0;
      mismatch     <= 1'b0;
      mismatch_vec <= '0;
      err_sticky   <= 1'b0;
      err_count    <= '0;
      chk_count    <= '0;
    end else begin
      golden_q <= jk_next(golden_q, J, K);
      mismatch <= 1'b0;
      // FAIL keeps the last miscompare vector visible for debug.
      if (state_q != FAIL) mismatch_vec <= '0;

      case (state_q)
        IDLE: begin
          state_q  <= RESTART;
          warm_cnt <= '0;
        end
        WARMUP: begin
          if (warm_cnt == WARM_LAST) state_q <= CHECK;
          else                       warm_cnt <= warm_cnt + 1'b1;
        end
        CHECK: begin
          if (en && !clear) begin
            mismatch_vec <= cmp_vec;
            mismatch     <= |cmp_vec;
            if (chk_count != CNT_MAX) chk_count <= chk_count + 1'b1;
            if (|cmp_vec) begin
              err_sticky <= 1'b1;
              if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
              if (STOP_ON_ERR) state_q <= FAIL;
            end
          end
        end
        default: ;
      endcase

      // Clear overrides everything above and resyncs the golden model to the
      // majority of the DUT outputs so a single faulty implementation can't steer it.
      if (clear && state_q != IDLE) begin
        state_q      <= RESTART;
        warm_cnt     <= '0;
        golden_q     <= jk_next(q_major, J, K);
        mismatch     <= 1'b0;
        mismatch_vec <= '0;
        err_sticky   <= 1'b0;
        err_count    <= '0;
        chk_count    <= '0;
      end
    end
  end

endmodule
